mii_rx_capture: RTL
===================

# mii_rx_capture

Parametrised MII receive capture engine: strips preamble/SFD, assembles nibbles into bytes, checks the Ethernet FCS and stores whole frames into a ring of buffer slots, each described by a queued descriptor. It sits directly behind the PHY RX pins, with `i_clk` tied to the MII RX clock. It replaces the single fixed 256-word capture buffer with a multi-frame, flow-controlled store that a consumer drains slot by slot.

## Interface

Parameters:
- `SLOTS`, 4: number of frame slots (power of two, 2..16).
- `SLOT_BYTES`, 2048: bytes per slot (power of two, ≥64).
- `LEN_W`, 12: width of the length field; must satisfy 2^LEN_W > SLOT_BYTES.

Ports:
- `i_clk`  in  1  MII RX clock; the only clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_rx_dv`  in  1  MII RX_DV.
- `i_rx_data`  in  4  MII RXD[3:0], bit 0 = first bit on the wire.
- `o_frame_valid`  out  1  descriptor FIFO non-empty; head descriptor outputs valid.
- `o_frame_slot`  out  $clog2(SLOTS)  slot holding the head frame.
- `o_frame_len`  out  LEN_W  head frame byte count, including FCS, saturated at SLOT_BYTES.
- `o_frame_crc_ok`  out  1  head frame FCS residue correct.
- `o_frame_err`  out  2  [0] truncated (frame exceeded SLOT_BYTES), [1] odd nibble count.
- `i_frame_release`  in  1  pulse: pop the head descriptor and free its slot.
- `i_rd_addr`  in  $clog2(SLOT_BYTES)  byte address within the head slot.
- `o_rd_data`  out  8  byte read from the head slot.
- `o_drop_count`  out  16  frames dropped (no free slot or bad preamble), saturating.
- `o_busy`  out  1  high while a frame is in progress (state ≠ IDLE).

## Operation

- Byte assembly: the first nibble after SFD is the low nibble, the second is the high nibble. Each second nibble writes one byte at `byte_cnt` and increments `byte_cnt`.
- FSM states:
  - IDLE → PRE: `i_rx_dv` high with data 0x5.
  - IDLE → DROP: `i_rx_dv` high with any other data.
  - PRE, data 0x5: stay in PRE.
  - PRE, data 0xD: go to DATA if a slot is free; otherwise go to DROP and increment `o_drop_count`.
  - PRE, any other data: go to DROP and increment `o_drop_count`.
  - PRE, `i_rx_dv` low: go to IDLE; nothing is counted.
  - DATA, `i_rx_dv` high: accept nibbles.
  - DATA, `i_rx_dv` low: commit the frame and go to IDLE.
  - DROP: wait for `i_rx_dv` low, then go to IDLE.
- Slot ring: the write pointer advances on commit and the head pointer advances on release. A slot is free when fewer than SLOTS descriptors are queued. Freeness is decided at the SFD, not afterwards.
- Truncation: bytes with `byte_cnt` ≥ SLOT_BYTES are not written. `byte_cnt` saturates at SLOT_BYTES and sets err[0]. CRC keeps running over all bytes.
- Odd nibble count at commit: the dangling nibble is discarded and err[1] is set.
- CRC: reflected CRC-32, polynomial 0xEDB88320, initial value 0xFFFFFFFF, updated per byte LSB-first. `crc_ok` = (register == 0xDEBB20E3) after the last byte, FCS included.
- Descriptor FIFO: depth SLOTS, holding {slot, len, crc_ok, err}. Commit always pushes, and space is guaranteed because the slot was reserved at SFD. Every frame that reaches DATA is committed, errored frames included.
- Release with `o_frame_valid` low is ignored.
- Commit and release on the same edge: both take effect and the occupancy count is unchanged.
- `i_rd_addr` is decoded relative to `o_frame_slot`.

## Timing

- Reset values: `o_frame_valid`=0, `o_frame_slot`=0, `o_frame_len`=0, `o_frame_crc_ok`=0, `o_frame_err`=0, `o_drop_count`=0, `o_busy`=0. `o_rd_data` is undefined until the first read.
- Reset mid-frame aborts the frame, frees all slots, clears the FIFO and returns to IDLE. Buffer RAM contents are not cleared.
- Each byte is written to RAM on the edge that samples its high nibble.
- Commit happens on the first edge that samples `i_rx_dv` low in DATA. `o_frame_valid` and the descriptor fields appear the following cycle (1-cycle latency from the dv fall).
- `o_rd_data` has 1-cycle latency: registered read of `i_rd_addr` and the current head slot.
- After `i_frame_release` at edge N:
  - the next descriptor is visible at edge N+1;
  - `o_frame_valid` falls at N+1 if the FIFO becomes empty.
- The freed slot is usable by an SFD sampled at edge N+1 or later.
- Minimum inter-frame gap is 1 cycle of `i_rx_dv` low; back-to-back frames must both be captured.
- `o_busy` is registered with the FSM state.

## Test plan

- 60-byte payload with correct FCS, preamble of 15×0x5 then 0xD → descriptor len=64, crc_ok=1, err=0, slot=0; every byte read back matches.
- Same frame with one corrupted data byte → len=64, crc_ok=0, err=0.
- 5 back-to-back frames with 1-cycle gaps, SLOTS=4, no release → 4 descriptors (slots 0..3), `o_drop_count`=1; releasing once then sending 1 more frame → it lands in slot 0.
- 2100-byte frame with SLOT_BYTES=2048 → len=2048, err[0]=1, crc_ok reflects the full frame; then a frame of 129 nibbles → err[1]=1, len=64.
- Release asserted on the same edge as a commit with 1 frame queued → `o_frame_valid` stays 1, new head is the just-committed frame, and occupancy is 1.
- `i_reset` asserted mid-DATA with 2 frames queued → next cycle `o_frame_valid`=0, `o_busy`=0, `o_drop_count`=0; the following good frame lands in slot 0.

Source files
------------

// File: rtl/mii_rx_capture_if.sv
// Frame descriptor and slot read bus between the MII capture engine and its consumer.
// The engine (master) presents the head descriptor; the consumer (slave) reads and releases it.
interface mii_rx_capture_if #(
  parameter int SLOTS      = 4,
  parameter int SLOT_BYTES = 2048,
  parameter int LEN_W      = 12
);
  localparam int SW = $clog2(SLOTS);
  localparam int AW = $clog2(SLOT_BYTES);

  logic             o_frame_valid;
  logic [SW-1:0]    o_frame_slot;
  logic [LEN_W-1:0] o_frame_len;
  logic             o_frame_crc_ok;
  logic [1:0]       o_frame_err;
  logic             i_frame_release;
  logic [AW-1:0]    i_rd_addr;
  logic [7:0]       o_rd_data;

  modport master (
    output o_frame_valid,
    output o_frame_slot,
    output o_frame_len,
    output o_frame_crc_ok,
    output o_frame_err,
    output o_rd_data,
    input  i_frame_release,
    input  i_rd_addr
  );

  modport slave (
    input  o_frame_valid,
    input  o_frame_slot,
    input  o_frame_len,
    input  o_frame_crc_ok,
    input  o_frame_err,
    input  o_rd_data,
    output i_frame_release,
    output i_rd_addr
  );
endinterface

// File: rtl/mii_rx_capture.sv
// MII receive capture: preamble/SFD strip, nibble-to-byte assembly, FCS check,
// and a ring of frame slots drained through a descriptor FIFO.
module mii_rx_capture #(
  parameter int SLOTS      = 4,
  parameter int SLOT_BYTES = 2048,
  parameter int LEN_W      = 12
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx_dv,
  input  logic [3:0]           i_rx_data,
  mii_rx_capture_if.master     frm,
  output logic [15:0]          o_drop_count,
  output logic                 o_busy
);
  localparam int SW = $clog2(SLOTS);
  localparam int AW = $clog2(SLOT_BYTES);
  localparam int CW = SW + 1;
  localparam logic [LEN_W-1:0] MAXLEN  = LEN_W'(SLOT_BYTES);
  localparam logic [31:0]      RESIDUE = 32'hDEBB20E3;
  localparam logic [31:0]      POLY    = 32'hEDB88320;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    DROP
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [3:0]       nib_q, nib_d;
  logic             half_q, half_d;
  logic             trunc_q, trunc_d;
  logic [31:0]      crc_q, crc_d;
  logic [SW-1:0]    wr_q, wr_d;
  logic [SW-1:0]    hd_q, hd_d;
  logic [CW-1:0]    occ_q, occ_d;
  logic [15:0]      drop_q, drop_d;
  logic [7:0]       rd_q;

  logic [7:0]       mem  [SLOTS*SLOT_BYTES];
  logic [LEN_W-1:0] dlen [SLOTS];
  logic             dcrc [SLOTS];
  logic [1:0]       derr [SLOTS];

  logic             we;
  logic [7:0]       wbyte;
  logic             commit;
  logic             rel;
  logic             slot_free;
  logic             valid;

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ ((r[0] ^ b[i]) ? POLY : 32'h0);
    end
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    nib_d     = nib_q;
    half_d    = half_q;
    trunc_d   = trunc_q;
    crc_d     = crc_q;
    drop_d    = drop_q;
    we        = 1'b0;
    commit    = 1'b0;
    wbyte     = {i_rx_data, nib_q};
    rel       = frm.i_frame_release && (occ_q != '0);
    slot_free = occ_q < CW'(SLOTS);

    unique case (state_q)
      IDLE: begin
        if (i_rx_dv) begin
          state_d = (i_rx_data == 4'h5) ? PRE : DROP;
        end
      end
      PRE: begin
        if (!i_rx_dv) begin
          state_d = IDLE;
        end else if (i_rx_data == 4'h5) begin
          state_d = PRE;
        end else if (i_rx_data == 4'hD && slot_free) begin
          state_d = DATA;
          cnt_d   = '0;
          half_d  = 1'b0;
          trunc_d = 1'b0;
          crc_d   = '1;
        end else begin
          state_d = DROP;
          drop_d  = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
        end
      end
      DATA: begin
        if (!i_rx_dv) begin
          commit  = 1'b1;
          state_d = IDLE;
        end else if (!half_q) begin
          nib_d  = i_rx_data;
          half_d = 1'b1;
        end else begin
          half_d = 1'b0;
          crc_d  = crc_byte(crc_q, wbyte);
          // Past the slot end the byte is dropped but still feeds the FCS
          if (cnt_q < MAXLEN) begin
            we    = 1'b1;
            cnt_d = cnt_q + LEN_W'(1);
          end else begin
            trunc_d = 1'b1;
          end
        end
      end
      DROP: begin
        if (!i_rx_dv) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_d  = commit ? wr_q + SW'(1) : wr_q;
    hd_d  = rel ? hd_q + SW'(1) : hd_q;
    occ_d = occ_q + CW'(commit) - CW'(rel);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      nib_q   <= '0;
      half_q  <= 1'b0;
      trunc_q <= 1'b0;
      crc_q   <= '1;
      wr_q    <= '0;
      hd_q    <= '0;
      occ_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nib_q   <= nib_d;
      half_q  <= half_d;
      trunc_q <= trunc_d;
      crc_q   <= crc_d;
      wr_q    <= wr_d;
      hd_q    <= hd_d;
      occ_q   <= occ_d;
      drop_q  <= drop_d;
    end
  end

  // Frame store and descriptor payload; contents survive reset
  always_ff @(posedge i_clk) begin
    if (we) begin
      mem[{wr_q, cnt_q[AW-1:0]}] <= wbyte;
    end
    if (commit) begin
      dlen[wr_q] <= cnt_q;
      dcrc[wr_q] <= (crc_q == RESIDUE);
      derr[wr_q] <= {half_q, trunc_q};
    end
    rd_q <= mem[{hd_q, frm.i_rd_addr}];
  end

  assign valid              = (occ_q != '0);
  assign frm.o_frame_valid  = valid;
  assign frm.o_frame_slot   = hd_q;
  assign frm.o_frame_len    = valid ? dlen[hd_q] : '0;
  assign frm.o_frame_crc_ok = valid ? dcrc[hd_q] : 1'b0;
  assign frm.o_frame_err    = valid ? derr[hd_q] : 2'b00;
  assign frm.o_rd_data      = rd_q;
  assign o_drop_count       = drop_q;
  assign o_busy             = (state_q != IDLE);
endmodule
